// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: idle-detect enable controller for a downstream clock-gate cell.
// Runs on the ungated clock. Drops `gate` after IDLE_CYCLES consecutive idle
// cycles, re-enables it on any activity, and acknowledges a wake request once
// the gated clock has run for WAKE_CYCLES cycles.
// Optional feature macro: CLKGATE_STATS_EN (gated-cycle counter).
module clkgate_ctrl #(
   parameter int unsigned IDLE_CYCLES = 16,  // 1..255
   parameter int unsigned WAKE_CYCLES = 2    // 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        busy,
   input  logic        force_on,
   input  logic        wake_req,
   output logic        wake_ack,
   output logic        gate,
   output logic [15:0] gated_cycles
);

   typedef enum logic [1:0] {
      ST_ON   = 2'd0,
      ST_OFF  = 2'd1,
      ST_WAKE = 2'd2
   } state_t;

   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
   localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

   state_t     state_q;
   logic [7:0] idle_cnt_q;
   logic [3:0] wake_cnt_q;
   logic       gate_q;
   logic       wake_ack_q;
   logic       activity;

   // Anything that needs the gated domain clocked counts as activity.
   assign activity = busy | force_on | wake_req;

   // Main FSM; gate and wake_ack are registered so the gate cell sees a clean,
   // edge-aligned enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ON;
         gate_q     <= 1'b1;
         wake_ack_q <= 1'b0;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
      end else begin
         // Ack only from ON, so a request dropped mid-wake never gets acked
         // and force_on alone never produces one.
         wake_ack_q <= wake_req & (state_q == ST_ON);
         case (state_q)
            ST_ON: begin
               if (activity) begin
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == IDLE_LAST) begin
                  state_q    <= ST_OFF;
                  gate_q     <= 1'b0;
                  idle_cnt_q <= '0;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 8'd1;
               end
            end
            ST_OFF: begin
               if (activity) begin
                  state_q    <= ST_WAKE;
                  gate_q     <= 1'b1;
                  wake_cnt_q <= '0;
               end
            end
            ST_WAKE: begin
               // Settle interval always runs to completion regardless of activity.
               if (wake_cnt_q == WAKE_LAST) begin
                  state_q    <= ST_ON;
                  idle_cnt_q <= '0;
               end else begin
                  wake_cnt_q <= wake_cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= ST_ON;
               gate_q  <= 1'b1;
            end
         endcase
      end
   end

   assign gate     = gate_q;
   assign wake_ack = wake_ack_q;

`ifdef CLKGATE_STATS_EN
   logic [15:0] gated_cycles_q;

   // Saturating count of edges where the registered gate was low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gated_cycles_q <= '0;
      end else if (!gate_q && (gated_cycles_q != 16'hFFFF)) begin
         gated_cycles_q <= gated_cycles_q + 16'd1;
      end
   end

   assign gated_cycles = gated_cycles_q;
`else
   assign gated_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb_clkgate_ctrl: directed steps plus randomized traffic, checked against a
// behavioural model that tracks the gate level, the length of the current idle
// run and the remaining settle cycles.
module tb_clkgate_ctrl;
   localparam int IDLE = 16;
   localparam int WAKE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy = 1'b0;
   logic        force_on = 1'b0;
   logic        wake_req = 1'b0;
   logic        wake_ack;
   logic        gate;
   logic [15:0] gated_cycles;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   bit m_gate = 1'b1;
   bit m_ack  = 1'b0;
   int m_run  = 0;   // consecutive idle cycles seen while fully on
   int m_left = 0;   // settle cycles still to run (0 = not waking)
   int m_gc   = 0;

   always #5 clk = ~clk;

   clkgate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
      .clk(clk), .rst_n(rst_n), .busy(busy), .force_on(force_on),
      .wake_req(wake_req), .wake_ack(wake_ack), .gate(gate),
      .gated_cycles(gated_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one rising edge to the model using the inputs currently driven.
   task automatic model_edge();
      bit act, fully_on;
      act      = busy | force_on | wake_req;
      fully_on = m_gate && (m_left == 0);
      if (!rst_n) begin
         m_gate = 1; m_ack = 0; m_run = 0; m_left = 0; m_gc = 0;
      end else begin
         m_ack = wake_req && fully_on;
`ifdef CLKGATE_STATS_EN
         if (!m_gate && m_gc < 65535) m_gc++;
`endif
         if (fully_on) begin
            if (act) m_run = 0;
            else if (m_run + 1 == IDLE) begin m_gate = 0; m_run = 0; end
            else m_run++;
         end else if (!m_gate) begin
            if (act) begin m_gate = 1; m_left = WAKE; end
         end else begin
            m_left--;
            if (m_left == 0) m_run = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("gate", 32'(gate), 32'(m_gate));
      chk("wake_ack", 32'(wake_ack), 32'(m_ack));
      chk("gated_cycles", 32'(gated_cycles), 32'(m_gc));
   endtask

   task automatic run_quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
      end
      #1;
   endtask

   task automatic idle_to_off();
      int n;
      busy = 0; force_on = 0; wake_req = 0;
      n = 0;
      while (m_gate && n < 300) begin step(); n++; end
      chk("reach_off_gate", 32'(gate), 32'd0);
   endtask

   initial begin
      int dens;
      // Reset state
      rst_n = 0;
      step(); step();
      chk("rst_gate", 32'(gate), 32'd1);
      chk("rst_ack", 32'(wake_ack), 32'd0);
      chk("rst_gc", 32'(gated_cycles), 32'd0);

      // Idle from reset release: gate high for 15 edges, low after the 16th
      rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("idle_gate", 32'(gate), 32'(i < 15));
      end

      // Busy pulse at idle cycle 10 restarts the idle run
      rst_n = 0; step(); rst_n = 1;
      for (int i = 0; i < 10; i++) step();
      busy = 1; step(); busy = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("pulse_gate", 32'(gate), 32'(i < 15));
      end

      // Wake request from OFF: gate at k, ack at k+3, ack drops one edge after req
      wake_req = 1;
      step();
      chk("wake_gate_k", 32'(gate), 32'd1);
      step(); chk("wake_ack_k1", 32'(wake_ack), 32'd0);
      step(); chk("wake_ack_k2", 32'(wake_ack), 32'd0);
      step(); chk("wake_ack_k3", 32'(wake_ack), 32'd1);
      wake_req = 0;
      step(); chk("wake_ack_drop", 32'(wake_ack), 32'd0);
      idle_to_off();

      // One-cycle force_on from OFF: settle, then 16 idle cycles, never an ack
      force_on = 1; step(); force_on = 0;
      chk("force_gate", 32'(gate), 32'd1);
      step(); step();
      for (int i = 0; i < 16; i++) begin
         step();
         chk("force_idle_gate", 32'(gate), 32'(i < 15));
         chk("force_no_ack", 32'(wake_ack), 32'd0);
      end

      // Reset during WAKE
      wake_req = 1; step();
      rst_n = 0; step();
      chk("wrst_gate", 32'(gate), 32'd1);
      chk("wrst_ack", 32'(wake_ack), 32'd0);
      rst_n = 1; wake_req = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wrst_no_ack", 32'(wake_ack), 32'd0);
      end
      idle_to_off();

      // Randomized traffic in phases of differing activity density
      dens = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(2))
               0: dens = 0;
               1: dens = 3;
               default: dens = 25;
            endcase
         end
         busy     = ($urandom_range(99) < dens);
         force_on = ($urandom_range(99) < dens / 4);
         if (wake_req) begin
            if (wake_ack ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0)) wake_req = 0;
         end else if ($urandom_range(99) < (dens == 0 ? 1 : dens / 3 + 1)) begin
            wake_req = 1;
         end
         rst_n = ($urandom_range(499) != 0);
         step();
      end
      rst_n = 1;

      // Gated-cycle statistics
      rst_n = 0; step(); rst_n = 1;
      idle_to_off();
`ifdef CLKGATE_STATS_EN
      run_quiet(70000);
      chk("gc_model", 32'(gated_cycles), 32'(m_gc));
      chk("gc_saturate", 32'(gated_cycles), 32'hFFFF);
      step();
      chk("gc_nowrap", 32'(gated_cycles), 32'hFFFF);
`else
      run_quiet(100);
      chk("gc_tied", 32'(gated_cycles), 32'h0);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
